// File: rtl/wb_arbiter.sv
// Writeback arbiter: accepts ALU and load results, formats loads, drives the register-file write port.
// Optional WB_RETIRE_CNT_EN adds the retired-write counter; otherwise retire_cnt is tied to zero.
module wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic [1:0]      mem_addr_lo,
    input  logic [2:0]      mem_funct3,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] regdata,
    output logic            wer,
    output logic            load_err,
    output logic [31:0]     retire_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    // Returns {error, formatted data}; error covers unknown funct3 and misaligned offsets.
    function automatic logic [XLEN:0] fmt_load(input logic [XLEN-1:0] data,
                                               input logic [1:0]      lo,
                                               input logic [2:0]      f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN:0] res;
        b   = data[{lo, 3'b000} +: 8];
        h   = lo[1] ? data[31:16] : data[15:0];
        res = {1'b1, {XLEN{1'b0}}};
        case (f3)
            3'b000:  res = {1'b0, {(XLEN-8){b[7]}}, b};
            3'b100:  res = {1'b0, {(XLEN-8){1'b0}}, b};
            3'b001:  res = {lo[0], {(XLEN-16){h[15]}}, h};
            3'b101:  res = {lo[0], {(XLEN-16){1'b0}}, h};
            3'b010:  res = {(lo != 2'b00), data};
            default: res = {1'b1, {XLEN{1'b0}}};
        endcase
        return res;
    endfunction

    logic [SW-1:0]   r_starve;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_regdata;
    logic            r_wer;
    logic            r_load_err;

    logic            w_alu_prio;
    logic            w_alu_ready;
    logic            w_mem_ready;
    logic            w_alu_acc;
    logic            w_mem_acc;
    logic [XLEN:0]   w_fmt;
    logic [4:0]      w_sel_rd;
    logic [XLEN-1:0] w_sel_data;
    logic            w_err;
    logic            w_commit;

    assign w_alu_prio = (r_starve == SW'(STARVE_MAX));
    assign w_fmt      = fmt_load(mem_rdata, mem_addr_lo, mem_funct3);

    // Grant: load wins contention unless the ALU has been refused STARVE_MAX times.
    always_comb begin
        w_alu_ready = 1'b0;
        w_mem_ready = 1'b0;
        if (rst_n) begin
            w_alu_ready = alu_valid && (!mem_valid || w_alu_prio);
            w_mem_ready = mem_valid && !(alu_valid && w_alu_prio);
        end else begin
            w_alu_ready = 1'b0;
            w_mem_ready = 1'b0;
        end
    end

    assign alu_ready = w_alu_ready;
    assign mem_ready = w_mem_ready;
    assign w_alu_acc = alu_valid && w_alu_ready;
    assign w_mem_acc = mem_valid && w_mem_ready;

    // Select the accepted source's destination, data and error status.
    always_comb begin
        w_sel_rd   = 5'd0;
        w_sel_data = {XLEN{1'b0}};
        w_err      = 1'b0;
        if (w_alu_acc) begin
            w_sel_rd   = alu_rd;
            w_sel_data = alu_result;
        end else if (w_mem_acc) begin
            w_sel_rd   = mem_rd;
            w_sel_data = w_fmt[XLEN-1:0];
            w_err      = w_fmt[XLEN];
        end else begin
            w_sel_rd   = 5'd0;
            w_sel_data = {XLEN{1'b0}};
            w_err      = 1'b0;
        end
    end

    assign w_commit = (w_alu_acc || w_mem_acc) && !w_err && (w_sel_rd != 5'd0);

    // Starvation counter for ALU requests refused while valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= {SW{1'b0}};
        end else if (!alu_valid || w_alu_acc) begin
            r_starve <= {SW{1'b0}};
        end else if (!w_alu_prio) begin
            r_starve <= r_starve + {{(SW-1){1'b0}}, 1'b1};
        end else begin
            r_starve <= r_starve;
        end
    end

    // Write-port register; rd/regdata only move on a real commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd       <= 5'd0;
            r_regdata  <= {XLEN{1'b0}};
            r_wer      <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wer      <= w_commit;
            r_load_err <= w_mem_acc && w_err;
            if (w_commit) begin
                r_rd      <= w_sel_rd;
                r_regdata <= w_sel_data;
            end else begin
                r_rd      <= r_rd;
                r_regdata <= r_regdata;
            end
        end
    end

    assign rd       = r_rd;
    assign regdata  = r_regdata;
    assign wer      = r_wer;
    assign load_err = r_load_err;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // Counts committed writes, advancing together with the write-enable register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= 32'h0;
        end else if (w_commit) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end else begin
            r_retire_cnt <= r_retire_cnt;
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: an arbitration/format model predicts each write, compared one cycle later.
module tb_wb_arbiter;

    localparam int SM = 4;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_addr_lo;
    logic [2:0]  mem_funct3;
    logic [4:0]  rd;
    logic [31:0] regdata;
    logic        wer;
    logic        load_err;
    logic [31:0] retire_cnt;

    wb_arbiter #(.XLEN(32), .STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_result(alu_result),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .mem_addr_lo(mem_addr_lo), .mem_funct3(mem_funct3),
        .rd(rd), .regdata(regdata), .wer(wer), .load_err(load_err), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          m_starve = 0;
    logic [4:0]  m_rd   = 5'd0;
    logic [31:0] m_data = 32'h0;
    logic [31:0] m_cnt  = 32'h0;

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [32:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                             input logic [2:0] f);
        logic [31:0] sh;
        sh = w >> (a * 8);
        case (f)
            3'b000:  return {1'b0, {24{sh[7]}}, sh[7:0]};
            3'b100:  return {1'b0, 24'h0, sh[7:0]};
            3'b001:  return {a[0], {16{sh[15]}}, sh[15:0]};
            3'b101:  return {a[0], 16'h0, sh[15:0]};
            3'b010:  return {(a != 2'b00), w};
            default: return {1'b1, 32'h0};
        endcase
    endfunction

    // One clock: predict grants, push expectation, cross the edge, pop and compare the write port.
    task automatic cyc(output logic a_acc, output logic m_acc);
        logic        e_ar, e_mr, e_wer, e_err;
        logic [32:0] f;
        exp_t        e;
        #1;
        e_ar = alu_valid && (!mem_valid || m_starve == SM);
        e_mr = mem_valid && !e_ar;
        chk_val("alu_ready", {31'h0, alu_ready}, {31'h0, e_ar});
        chk_val("mem_ready", {31'h0, mem_ready}, {31'h0, e_mr});
        if (e_ar) begin
            e.rd = alu_rd; e.data = alu_result; e.err = 1'b0;
            sb_q.push_back(e);
        end else if (e_mr) begin
            f = ref_load(mem_rdata, mem_addr_lo, mem_funct3);
            e.rd = mem_rd; e.data = f[31:0]; e.err = f[32];
            sb_q.push_back(e);
        end
        m_starve = (!alu_valid || e_ar) ? 0 : ((m_starve < SM) ? m_starve + 1 : SM);
        a_acc = e_ar;
        m_acc = e_mr;
        @(posedge clk);
        #1;
        e_wer = 1'b0;
        e_err = 1'b0;
        if ((e_ar || e_mr) && sb_q.size() > 0) begin
            e     = sb_q.pop_front();
            e_err = e.err;
            e_wer = !e.err && (e.rd != 5'd0);
            if (e_wer) begin
                m_rd   = e.rd;
                m_data = e.data;
                m_cnt  = m_cnt + 32'd1;
            end
        end
        chk_val("wer", {31'h0, wer}, {31'h0, e_wer});
        chk_val("load_err", {31'h0, load_err}, {31'h0, e_err});
        chk_val("rd", {27'h0, rd}, {27'h0, m_rd});
        chk_val("regdata", regdata, m_data);
`ifdef WB_RETIRE_CNT_EN
        chk_val("retire_cnt", retire_cnt, m_cnt);
`else
        chk_val("retire_cnt", retire_cnt, 32'h0);
`endif
    endtask

    logic [2:0]  t_f3[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  t_lo[5]  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] t_exp[5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};

    initial begin
        logic aa, ma;
        int   first_alu;
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_result = 32'h1;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_rdata = 32'h2;
        mem_addr_lo = 2'd0; mem_funct3 = 3'b010;
        #3;
        chk_val("rst_rd", {27'h0, rd}, 32'h0);
        chk_val("rst_regdata", regdata, 32'h0);
        chk_val("rst_wer", {31'h0, wer}, 32'h0);
        chk_val("rst_alu_ready", {31'h0, alu_ready}, 32'h0);
        chk_val("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        chk_val("rst_retire", retire_cnt, 32'h0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Lone ALU writes, then contention traffic ahead of a mid-stream reset.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1; alu_rd = 5'(10 + i); alu_result = 32'hA000 + 32'(i);
            cyc(aa, ma);
        end
        mem_valid = 1'b1; mem_rd = 5'd4; mem_rdata = 32'hCAFE0001;
        cyc(aa, ma);
        cyc(aa, ma);
        rst_n = 1'b0;
        #1;
        chk_val("mid_rst_rd", {27'h0, rd}, 32'h0);
        chk_val("mid_rst_regdata", regdata, 32'h0);
        chk_val("mid_rst_wer", {31'h0, wer}, 32'h0);
        chk_val("mid_rst_alu_ready", {31'h0, alu_ready}, 32'h0);
        chk_val("mid_rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        chk_val("mid_rst_retire", retire_cnt, 32'h0);
        sb_q.delete();
        m_starve = 0; m_rd = 5'd0; m_data = 32'h0; m_cnt = 32'h0;
        @(posedge clk);
        #1;
        chk_val("rst_hold_wer", {31'h0, wer}, 32'h0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        alu_valid = 1'b1; alu_rd = 5'd5; alu_result = 32'h1234;
        cyc(aa, ma);
        chk_val("first_alu_regdata", regdata, 32'h00001234);
        alu_valid = 1'b0;

        // Load formatting of one word under every legal load type.
        mem_valid = 1'b1; mem_rd = 5'd3; mem_rdata = 32'h80FF7F01;
        for (int i = 0; i < 5; i++) begin
            mem_funct3 = t_f3[i]; mem_addr_lo = t_lo[i];
            cyc(aa, ma);
            chk_val("load_fmt", regdata, t_exp[i]);
        end
        mem_funct3 = 3'b010; mem_addr_lo = 2'd2;
        cyc(aa, ma);
        mem_funct3 = 3'b011; mem_addr_lo = 2'd0;
        cyc(aa, ma);
        mem_valid = 1'b0;
        cyc(aa, ma);

        // Sustained contention: ALU holds its data until granted.
        first_alu = -1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_result = 32'h7777_0000;
        mem_valid = 1'b1; mem_funct3 = 3'b010; mem_addr_lo = 2'd0;
        for (int i = 0; i < 12; i++) begin
            mem_rd = 5'(16 + i); mem_rdata = 32'hBEEF_0000 + 32'(i);
            cyc(aa, ma);
            if (aa) begin
                if (first_alu < 0) first_alu = i;
                alu_result = alu_result + 32'd1;
            end
        end
        chk_val("starve_grant_cycle", 32'(first_alu), 32'd4);
        alu_valid = 1'b0; mem_valid = 1'b0;
        cyc(aa, ma);

        // Writes to x0 complete the handshake but never commit.
        alu_valid = 1'b1; alu_rd = 5'd0; alu_result = 32'hDEAD_BEEF;
        cyc(aa, ma);
        alu_rd = 5'd31; alu_result = 32'h3131_3131;
        cyc(aa, ma);
        alu_valid = 1'b0;
        cyc(aa, ma);

`ifdef WB_RETIRE_CNT_EN
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_retire_cnt;
        m_cnt = 32'hFFFF_FFFF;
        chk_val("retire_preset", retire_cnt, 32'hFFFF_FFFF);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_result = 32'h99;
        cyc(aa, ma);
        chk_val("retire_wrap", retire_cnt, 32'h0);
        alu_valid = 1'b0;
        cyc(aa, ma);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
